// File: rtl/fmc_adc_delay_ctrl_if.sv
// Command/response handshake between the host-side sequencer user and
// fmc_adc_delay_ctrl. The master issues tap commands; the slave returns one status word per command.
interface fmc_adc_delay_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_adc;
  logic [4:0]  req_tap;
  logic [16:0] req_select;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic        resp_sat;
  logic [4:0]  resp_tap;

  modport master (
    output req_valid, req_op, req_adc, req_tap, req_select,
    input  req_ready, resp_valid, resp_err, resp_sat, resp_tap
  );

  modport slave (
    input  req_valid, req_op, req_adc, req_tap, req_select,
    output req_ready, resp_valid, resp_err, resp_sat, resp_tap
  );
endinterface

// File: rtl/fmc_adc_delay_ctrl.sv
// IDELAY tap sequencer (sys_clk domain). Takes one SET/INC/DEC command at a
// time, drives delay_reg/select/load of the target ADC, waits for delay_rdy,
// reads the tap back and returns one status word.
// Optional build macro: FMC_ADC_DELAY_CTRL_READBACK_CHECK_EN flags a readback
// that differs from the loaded target with err=2.
module fmc_adc_delay_ctrl #(
  parameter int NUM_ADC        = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  fmc_adc_delay_ctrl_if.slave     bus,
  output logic [NUM_ADC-1:0][4:0]  dly_reg_o,
  output logic [NUM_ADC-1:0][16:0] dly_select_o,
  output logic [NUM_ADC-1:0]       dly_load_o,
  input  logic [NUM_ADC-1:0][4:0]  dly_reg_read_i,
  input  logic [NUM_ADC-1:0]       dly_rdy_i
);

  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_INC = 2'd1;
  localparam logic [1:0] OP_DEC = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  localparam logic [1:0] E_OK      = 2'd0;
  localparam logic [1:0] E_TIMEOUT = 2'd1;
  localparam logic [1:0] E_RBACK   = 2'd2;
  localparam logic [1:0] E_BADREQ  = 2'd3;

  // One counter serves both the settle delay and the rdy timeout.
  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK_RDY, S_LOAD, S_SETTLE, S_WAIT_DONE, S_CHECK, S_RESP
  } state_t;

  state_t        state_q, state_n;
  logic [1:0]    op_q, adc_q, err_q;
  logic [4:0]    tap_q, tgt_q, rb_q;
  logic [16:0]   sel_q;
  logic          sat_q;
  logic [CW-1:0] cnt_q;

  logic       accept, bad_req, rdy, tmo, settled, sat_n;
  logic [4:0] cur, tgt_n;

  assign accept  = bus.req_valid & bus.req_ready;
  assign bad_req = (bus.req_op == OP_RSV) || ({1'b0, bus.req_adc} >= 3'(NUM_ADC));
  assign rdy     = dly_rdy_i[adc_q];
  assign cur     = dly_reg_read_i[adc_q];
  assign tmo     = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign settled = (cnt_q == CW'(SETTLE_CYCLES - 1));

  // Target tap from the current readback; INC/DEC clamp at the tap range ends.
  always_comb begin
    tgt_n = tap_q;
    sat_n = 1'b0;
    case (op_q)
      OP_INC: begin
        if (cur == 5'd31) sat_n = 1'b1;
        else              tgt_n = cur + 5'd1;
        if (cur == 5'd31) tgt_n = 5'd31;
      end
      OP_DEC: begin
        if (cur == 5'd0) sat_n = 1'b1;
        else             tgt_n = cur - 5'd1;
        if (cur == 5'd0) tgt_n = 5'd0;
      end
      default: tgt_n = tap_q;
    endcase
  end

  // Next-state logic; rdy wins over a coincident timeout.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_n = bad_req ? S_RESP : S_CHK_RDY;
      S_CHK_RDY:   if (rdy) state_n = S_LOAD; else if (tmo) state_n = S_RESP;
      S_LOAD:      state_n = S_SETTLE;
      S_SETTLE:    if (settled) state_n = S_WAIT_DONE;
      S_WAIT_DONE: if (rdy) state_n = S_CHECK; else if (tmo) state_n = S_RESP;
      S_CHECK:     state_n = S_RESP;
      S_RESP:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // State register plus command datapath and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_SET;
      adc_q          <= '0;
      tap_q          <= '0;
      sel_q          <= '0;
      tgt_q          <= '0;
      sat_q          <= 1'b0;
      err_q          <= E_OK;
      rb_q           <= '0;
      cnt_q          <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= '0;
      bus.resp_sat   <= 1'b0;
      bus.resp_tap   <= '0;
      dly_reg_o      <= '0;
      dly_select_o   <= '0;
      dly_load_o     <= '0;
    end else begin
      state_q        <= state_n;
      // Ready only after a full idle cycle, so never alongside resp_valid.
      bus.req_ready  <= (state_q == S_IDLE) && (state_n == S_IDLE);
      bus.resp_valid <= 1'b0;
      dly_load_o     <= '0;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q  <= bus.req_op;
          adc_q <= bus.req_adc;
          tap_q <= bus.req_tap;
          sel_q <= bus.req_select;
          sat_q <= 1'b0;
          rb_q  <= '0;
          err_q <= bad_req ? E_BADREQ : E_OK;
          cnt_q <= '0;
        end
        S_CHK_RDY: begin
          if (rdy) begin
            tgt_q <= tgt_n;
            sat_q <= sat_n;
          end else if (tmo) begin
            err_q <= E_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOAD: begin
          dly_reg_o[adc_q]    <= tgt_q;
          dly_select_o[adc_q] <= sel_q;
          dly_load_o[adc_q]   <= 1'b1;
          cnt_q               <= '0;
        end
        S_SETTLE: cnt_q <= settled ? '0 : cnt_q + 1'b1;
        S_WAIT_DONE: begin
          if (!rdy) begin
            if (tmo) begin
              err_q        <= E_TIMEOUT;
              dly_reg_o    <= '0;
              dly_select_o <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          rb_q         <= cur;
          dly_reg_o    <= '0;
          dly_select_o <= '0;
`ifdef FMC_ADC_DELAY_CTRL_READBACK_CHECK_EN
          if (cur != tgt_q) err_q <= E_RBACK;
`endif
        end
        S_RESP: begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= err_q;
          bus.resp_sat   <= sat_q;
          bus.resp_tap   <= rb_q;
        end
        default: ;
      endcase
    end
  end

endmodule
